// File: rtl/draw_background_scroll_pkg.sv
// ============================================================================
// draw_background_scroll_pkg : shared types and level palettes for the painter
// Rev 1.0
// ============================================================================
`default_nettype none

package draw_background_scroll_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

  localparam logic [11:0] BG_MAIN   = 12'h115;
  localparam logic [11:0] FLASH_RGB = 12'hFFF;
  localparam logic [11:0] BLANK_RGB = 12'h000;

  // Levels 1..3 keep the original game colours; out-of-range falls back to level 1.
  function automatic logic [11:0] strip_rgb(input logic [3:0] lvl);
    case (lvl)
      4'd2:    strip_rgb = 12'ha70;
      4'd3:    strip_rgb = 12'h609;
      4'd4:    strip_rgb = 12'h0a5;
      4'd5:    strip_rgb = 12'h55a;
      4'd6:    strip_rgb = 12'ha55;
      4'd7:    strip_rgb = 12'h888;
      4'd8:    strip_rgb = 12'h0aa;
      default: strip_rgb = 12'h096;
    endcase
  endfunction

  function automatic logic [11:0] strip_sh_rgb(input logic [3:0] lvl);
    case (lvl)
      4'd2:    strip_sh_rgb = 12'ha90;
      4'd3:    strip_sh_rgb = 12'ha0f;
      4'd4:    strip_sh_rgb = 12'h083;
      4'd5:    strip_sh_rgb = 12'h33c;
      4'd6:    strip_sh_rgb = 12'hc33;
      4'd7:    strip_sh_rgb = 12'h666;
      4'd8:    strip_sh_rgb = 12'h088;
      default: strip_sh_rgb = 12'h064;
    endcase
  endfunction

  function automatic logic [11:0] main_sh_rgb(input logic [3:0] lvl);
    case (lvl)
      4'd2:    main_sh_rgb = 12'h046;
      4'd3:    main_sh_rgb = 12'h203;
      4'd4:    main_sh_rgb = 12'h021;
      4'd5:    main_sh_rgb = 12'h112;
      4'd6:    main_sh_rgb = 12'h211;
      4'd7:    main_sh_rgb = 12'h222;
      4'd8:    main_sh_rgb = 12'h022;
      default: main_sh_rgb = 12'h118;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/draw_background_scroll_frame_ctrl.sv
// ============================================================================
// bg_frame_ctrl : per-frame control (level latch, flash FSM, scroll divider)
// Rev 1.0
// ============================================================================
`default_nettype none

module bg_frame_ctrl
  import draw_background_scroll_pkg::*;
#(
  parameter int NUM_LEVELS    = 3,
  parameter int STRIPE_PERIOD = 32,
  parameter int SCROLL_DIV    = 2,
  parameter int FLASH_FRAMES  = 16,
  parameter int SCROLL_W      = $clog2(STRIPE_PERIOD)
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic                vsync_in,
  input  logic [3:0]          level,
  input  logic                pause,
  output logic [3:0]          level_q,
  output logic [SCROLL_W-1:0] scroll,
  output logic                flash_on,
  output logic                flash_active
);

  flash_state_t state;
  logic [7:0]   flash_cnt;
  logic [3:0]   div_cnt;
  logic         vsync_d;
  logic         fs;
  logic [3:0]   lvl_s;
  logic         lvl_change;

  assign fs         = vsync_in & ~vsync_d;
  assign lvl_s      = ((level >= 4'd1) && (level <= 4'(NUM_LEVELS))) ? level : 4'd1;
  assign lvl_change = (lvl_s != level_q);

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vsync_d   <= 1'b0;
      level_q   <= 4'd1;
      flash_cnt <= 8'd0;
      state     <= IDLE;
      div_cnt   <= 4'd0;
      scroll    <= '0;
    end else begin
      vsync_d <= vsync_in;
      if (fs) begin
        // A new level restarts the flash even if one is already running.
        if (lvl_change) begin
          level_q   <= lvl_s;
          flash_cnt <= 8'(FLASH_FRAMES);
          state     <= FLASH;
        end else if (state == FLASH) begin
          if (flash_cnt == 8'd1) begin
            flash_cnt <= 8'd0;
            state     <= IDLE;
          end else begin
            flash_cnt <= flash_cnt - 8'd1;
          end
        end
        if (!pause) begin
          if (div_cnt == 4'(SCROLL_DIV - 1)) begin
            div_cnt <= 4'd0;
            scroll  <= scroll + 1'b1;
          end else begin
            div_cnt <= div_cnt + 4'd1;
          end
        end
      end
    end
  end

  assign flash_active = (state == FLASH);
  assign flash_on     = (state == FLASH) & flash_cnt[1];

endmodule

`default_nettype wire

// File: rtl/draw_background_scroll.sv
// ============================================================================
// draw_background_scroll : level background painter with scrolling side strips
// Rev 1.0
// ============================================================================
`default_nettype none

module draw_background_scroll
  import draw_background_scroll_pkg::*;
#(
  parameter int H_ACTIVE      = 1024,
  parameter int STRIP_W       = 76,
  parameter int SH_W          = 4,
  parameter int NUM_LEVELS    = 3,
  parameter int STRIPE_PERIOD = 32,
  parameter int SCROLL_DIV    = 2,
  parameter int FLASH_FRAMES  = 16
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [3:0]  level,
  input  logic        pause,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic        flash_active
);

  localparam int SCROLL_W = $clog2(STRIPE_PERIOD);

  localparam logic [10:0] L_STRIP = 11'(STRIP_W);
  localparam logic [10:0] L_SSH   = 11'(STRIP_W + SH_W);
  localparam logic [10:0] L_MSH   = 11'(STRIP_W + 2 * SH_W);
  localparam logic [10:0] R_STRIP = 11'(H_ACTIVE - STRIP_W);
  localparam logic [10:0] R_SSH   = 11'(H_ACTIVE - STRIP_W - SH_W);
  localparam logic [10:0] R_MSH   = 11'(H_ACTIVE - STRIP_W - 2 * SH_W);

  if (STRIP_W + 2 * SH_W >= H_ACTIVE / 2) begin : g_bad_geometry
    $error("draw_background_scroll: side bands overlap the screen centre");
  end
  if (NUM_LEVELS < 1 || NUM_LEVELS > 8) begin : g_bad_levels
    $error("draw_background_scroll: NUM_LEVELS must be 1..8");
  end
  if (STRIPE_PERIOD < 4 || STRIPE_PERIOD > 256 ||
      (STRIPE_PERIOD & (STRIPE_PERIOD - 1)) != 0) begin : g_bad_period
    $error("draw_background_scroll: STRIPE_PERIOD must be a power of two in 4..256");
  end

  logic [3:0]          level_q;
  logic [SCROLL_W-1:0] scroll;
  logic                flash_on;
  logic [SCROLL_W-1:0] phase;
  logic                alt;
  logic                in_strip, in_ssh, in_msh;
  logic [11:0]         rgb_next;

  bg_frame_ctrl #(
    .NUM_LEVELS    (NUM_LEVELS),
    .STRIPE_PERIOD (STRIPE_PERIOD),
    .SCROLL_DIV    (SCROLL_DIV),
    .FLASH_FRAMES  (FLASH_FRAMES),
    .SCROLL_W      (SCROLL_W)
  ) u_frame_ctrl (
    .pclk         (pclk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .level        (level),
    .pause        (pause),
    .level_q      (level_q),
    .scroll       (scroll),
    .flash_on     (flash_on),
    .flash_active (flash_active)
  );

  // Only the low bits of the difference matter, so the subtract is done at phase width.
  assign phase = vcount_in[SCROLL_W-1:0] - scroll;
  assign alt   = (phase >= SCROLL_W'(STRIPE_PERIOD / 2));

  assign in_strip = (hcount_in < L_STRIP) || (hcount_in >= R_STRIP);
  assign in_ssh   = (hcount_in < L_SSH)   || (hcount_in >= R_SSH);
  assign in_msh   = (hcount_in < L_MSH)   || (hcount_in >= R_MSH);

  always_comb begin
    rgb_next = BG_MAIN;
    if (vblnk_in || hblnk_in)
      rgb_next = BLANK_RGB;
    else if (in_strip)
      rgb_next = alt ? strip_sh_rgb(level_q) : strip_rgb(level_q);
    else if (in_ssh)
      rgb_next = strip_sh_rgb(level_q);
    else if (in_msh)
      rgb_next = main_sh_rgb(level_q);
    else if (flash_on)
      rgb_next = FLASH_RGB;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vcount_out <= 11'd0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hcount_out <= 11'd0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= BLANK_RGB;
    end else begin
      vcount_out <= vcount_in;
      vsync_out  <= vsync_in;
      vblnk_out  <= vblnk_in;
      hcount_out <= hcount_in;
      hsync_out  <= hsync_in;
      hblnk_out  <= hblnk_in;
      rgb_out    <= rgb_next;
    end
  end

endmodule

`default_nettype wire

// File: doc/draw_background_scroll.md
Name: draw_background_scroll

Overview:
- Next-generation level background painter for the VGA pixel pipeline.
- First stage after the timing generator; feeds the sprite/char overlay stages.
- Adds over the current painter:
  - geometry set by parameters;
  - up to 8 level palettes;
  - a downward-scrolling stripe pattern on the side strips;
  - a frame-counted white flash on level change, with level latched only at frame boundaries.

Parameters:
- H_ACTIVE, 1024: active pixels per line.
- STRIP_W, 76: width of each side strip in pixels.
- SH_W, 4: width of each strip-shadow band and each main-shadow band.
- NUM_LEVELS, 3: number of valid palettes, 1..8.
- STRIPE_PERIOD, 32: vertical period of the side-strip stripe pattern. Power of two, 4..256.
- SCROLL_DIV, 2: frames per 1-pixel scroll step, 1..15.
- FLASH_FRAMES, 16: length of the level-change flash in frames, 2..255.

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- vcount_in  in  11  vertical count.
- vsync_in  in  1  vertical sync.
- vblnk_in  in  1  vertical blank.
- hcount_in  in  11  horizontal count.
- hsync_in  in  1  horizontal sync.
- hblnk_in  in  1  horizontal blank.
- level  in  4  requested game level, 1-based.
- pause  in  1  freezes the scroll when high.
- vcount_out  out  11  delayed vcount.
- vsync_out  out  1  delayed vsync.
- vblnk_out  out  1  delayed vblank.
- hcount_out  out  11  delayed hcount.
- hsync_out  out  1  delayed hsync.
- hblnk_out  out  1  delayed hblank.
- rgb_out  out  12  pixel colour, 4:4:4.
- flash_active  out  1  high while the flash FSM is in FLASH.

Behaviour:
- Clock and reset: one clock, pclk. rst is asynchronous, active-high. All flops clear on rst assertion, regardless of clock.
- Reset values:
  - all timing outputs 0; rgb_out 12'h000; flash_active 0;
  - level_q 1; scroll 0; div_cnt 0; flash_cnt 0; FSM IDLE; vsync_d 0.
- Latency: exactly 1 cycle from every *_in to its *_out. rgb_out is aligned with the delayed counts.
- Frame start: single-cycle pulse fs = vsync_in & ~vsync_d. vsync_d is vsync_in registered.
- Level sanitising: lvl_s = level if 1 ≤ level ≤ NUM_LEVELS, else 1.
- Level latch: at fs only, if lvl_s ≠ level_q:
  - level_q ← lvl_s;
  - flash_cnt ← FLASH_FRAMES;
  - FSM → FLASH.
  A level change mid-frame has no visible effect until the next fs.
- Flash FSM:
  - IDLE: on a level change at fs → FLASH.
  - FLASH:
    - at each fs with no level change, flash_cnt decrements;
    - when flash_cnt is 1 at fs → IDLE with flash_cnt 0;
    - a level change at fs during FLASH reloads FLASH_FRAMES and stays in FLASH.
  - flash_active = (state == FLASH).
- Scroll:
  - at fs with pause = 0, div_cnt increments;
  - when div_cnt reaches SCROLL_DIV−1, div_cnt ← 0 and scroll ← (scroll + 1) mod STRIPE_PERIOD;
  - pause = 1 holds both div_cnt and scroll;
  - scroll wraps silently.
- Stripe select:
  - phase = (vcount_in − scroll) mod STRIPE_PERIOD, computed with an 11-bit subtract then masking the low log2(STRIPE_PERIOD) bits;
  - alt = phase ≥ STRIPE_PERIOD/2;
  - as scroll grows, the pattern moves down.
- Colour selection (combinational from *_in and level_q, registered into rgb_out), first match wins:
  1. vblnk_in | hblnk_in → 12'h000.
  2. hcount < STRIP_W, or hcount ≥ H_ACTIVE−STRIP_W → STRIP[level_q] if ~alt, else STRIP_SH[level_q].
  3. hcount < STRIP_W+SH_W, or hcount ≥ H_ACTIVE−STRIP_W−SH_W → STRIP_SH[level_q].
  4. hcount < STRIP_W+2·SH_W, or hcount ≥ H_ACTIVE−STRIP_W−2·SH_W → MAIN_SH[level_q].
  5. Otherwise:
     - 12'hFFF if state == FLASH and flash_cnt[1] == 1;
     - else BG_MAIN.
- Flash coverage: the flash affects only the main area. Strips keep the palette of the new level.
- Count width: hcount and vcount comparisons are 11-bit unsigned. Parameters are checked at elaboration: STRIP_W + 2·SH_W < H_ACTIVE/2.

Decomposition:
- Shared include bg_palette.vh holds:
  - BG_MAIN = 12'h115;
  - palette tables STRIP, STRIP_SH, MAIN_SH indexed 1..8. Levels 1..3 keep the existing game colours:
    - L1: 096, 064, 118;
    - L2: a70, a90, 046;
    - L3: 609, a0f, 203;
  - FLASH_RGB = 12'hFFF.
- Sub-module bg_frame_ctrl owns the per-frame control:
  - vsync edge detect;
  - level latch;
  - flash FSM and counter;
  - scroll divider.
  - It outputs level_q, scroll, flash_on, flash_active.
- The top level keeps the pixel path and the 1-cycle register stage.

Test Plan:
- Reset mid-line (rst pulsed asynchronously between clock edges) → all outputs 0 immediately; after release, level 1 colours appear with scroll 0 and flash_active 0.
- Level 1, scroll 0, pause = 1:
  - hcount 10, vcount 5 → 12'h096;
  - hcount 10, vcount 20 → 12'h064;
  - hcount 78 → 12'h064;
  - hcount 82 → 12'h118;
  - hcount 500 → 12'h115;
  - hcount 1000 → 12'h096;
  - hblnk_in high → 12'h000;
  - every output lags its input by 1 cycle.
- Level 1 → 2 mid-frame:
  - colours unchanged until the next vsync rising edge;
  - then flash_active = 1 for exactly 16 frames;
  - main area is 12'hFFF in frames with flash_cnt 15, 14, 11, 10, 7, 6, 3, 2, else 12'h115;
  - strips show 12'ha70.
- Level 3 → 1 at frame 5 of a flash → flash_cnt reloads to 16 and flash_active stays high for 16 further frames.
- level = 0 and level = 9 → treated as level 1: level-1 colours, no flash if level_q is already 1.
- pause = 0, SCROLL_DIV = 2:
  - scroll steps once every 2 frames;
  - after 64 frames scroll wraps back to 0;
  - at scroll 1, the pixel at vcount 16, hcount 10 is 12'h096.
